reservation_stations: RTL and testbench

Reservation-station array between the scheduler (dispatch) and the execute stage (issue). It stores the `rs_entry` the scheduler builds at the slot index the scheduler selects. It snoops both CDBs to wake up operands still waiting on ROB tags, and issues one ready entry per cycle to execute over a valid/ready handshake. Its `res_stations` output is the array the scheduler scans to find a free station.

---
 rtl/reservation_stations.sv | 191 +++++++++++++++++++
 tb/tb_reservation_stations.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_stations.sv
// Reservation-station array: dispatch write, dual-CDB operand wakeup, one issue per cycle.
// Build option: define RS_OLDEST_FIRST_EN to issue the oldest ready entry (per-slot age counters).
`ifndef RS_SIZE
`define RS_SIZE 8
`endif

module reservation_stations #(
    parameter int RS_SIZE = `RS_SIZE,
    parameter int AGE_W   = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 8,
    parameter int LSQ_W   = 4,
    localparam int ID_W    = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1,
    localparam int ENTRY_W = 1 + 3 * TAG_W + 3 * DATA_W + CTRL_W + LSQ_W,
    localparam int CDB_W   = TAG_W + DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       dispatch_valid,
    input  logic [ID_W-1:0]            dispatch_id,
    input  logic [ENTRY_W-1:0]         dispatch_entry,
    input  logic [CDB_W-1:0]           cdb1,
    input  logic [CDB_W-1:0]           cdb2,
    input  logic                       issue_ready,
    output logic [RS_SIZE*ENTRY_W-1:0] res_stations,
    output logic                       issue_valid,
    output logic [ENTRY_W-1:0]         issue_entry,
    output logic [ID_W-1:0]            issue_id,
    output logic                       rs_full,
    output logic                       dispatch_err
);

    // Field order (MSB first) is the packed layout seen on dispatch_entry and res_stations.
    typedef struct packed {
        logic              busy;
        logic [TAG_W-1:0]  tag;
        logic [TAG_W-1:0]  tag_1;
        logic [TAG_W-1:0]  tag_2;
        logic [DATA_W-1:0] value_1;
        logic [DATA_W-1:0] value_2;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl_bits;
        logic [LSQ_W-1:0]  lsq_id;
    } rs_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_t;

    cdb_t      cdb1_s;
    cdb_t      cdb2_s;
    rs_entry_t dispatch_s;

    rs_entry_t [RS_SIZE-1:0]            rs_q;
    logic      [RS_SIZE-1:0][AGE_W-1:0] age_val;
    logic      [RS_SIZE-1:0]            busy;
    logic      [RS_SIZE-1:0]            ready;
    logic      [RS_SIZE-1:0]            busy_next;
    logic      [RS_SIZE-1:0]            err_slot;

    logic             sel_found;
    logic [ID_W-1:0]  sel_id;
    logic [AGE_W-1:0] best_age;
    logic             issue_fire;
    logic             rs_full_reg;
    logic             dispatch_err_reg;

    assign cdb1_s     = cdb_t'(cdb1);
    assign cdb2_s     = cdb_t'(cdb2);
    assign dispatch_s = rs_entry_t'(dispatch_entry);

    // Resolve each waiting operand from the buses; cdb1 wins when both carry the same tag.
    function automatic rs_entry_t wake(input rs_entry_t e, input cdb_t c1, input cdb_t c2);
        rs_entry_t w;
        w = e;
        if (w.tag_1 != '0) begin
            if (c1.tag == w.tag_1) begin
                w.value_1 = c1.value;
                w.tag_1   = '0;
            end else if (c2.tag == w.tag_1) begin
                w.value_1 = c2.value;
                w.tag_1   = '0;
            end
        end
        if (w.tag_2 != '0) begin
            if (c1.tag == w.tag_2) begin
                w.value_2 = c1.value;
                w.tag_2   = '0;
            end else if (c2.tag == w.tag_2) begin
                w.value_2 = c2.value;
                w.tag_2   = '0;
            end
        end
        return w;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_slot
            rs_entry_t slot_reg;
            rs_entry_t slot_next;
            logic      hit;
            logic      issued;

            assign busy[gi]  = slot_reg.busy;
            assign ready[gi] = slot_reg.busy && (slot_reg.tag_1 == '0) && (slot_reg.tag_2 == '0);
            assign hit       = dispatch_valid && (dispatch_id == ID_W'(gi));
            assign issued    = issue_fire && (sel_id == ID_W'(gi));
            // A slot leaving through issue this cycle still refuses the write, but silently.
            assign err_slot[gi] = hit && slot_reg.busy && !issued;

            always_comb begin
                slot_next = slot_reg;
                if (issued) begin
                    slot_next = '0;
                end else if (slot_reg.busy) begin
                    slot_next = wake(slot_reg, cdb1_s, cdb2_s);
                end else if (hit) begin
                    slot_next      = wake(dispatch_s, cdb1_s, cdb2_s);
                    slot_next.busy = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            assign busy_next[gi] = slot_next.busy;
            assign rs_q[gi]      = slot_reg;
            assign res_stations[gi*ENTRY_W +: ENTRY_W] = slot_reg;

`ifdef RS_OLDEST_FIRST_EN
            logic [AGE_W-1:0] age_reg;

            // Age restarts at 0 on the write edge and counts while the slot stays occupied.
            always_ff @(posedge clk) begin
                if (reset || flush || issued || !slot_reg.busy) begin
                    age_reg <= '0;
                end else if (age_reg != {AGE_W{1'b1}}) begin
                    age_reg <= age_reg + 1'b1;
                end
            end

            assign age_val[gi] = age_reg;
`else
            assign age_val[gi] = '0;
`endif
        end
    endgenerate

    // Strict greater-than keeps the lowest index on equal age; with ages tied at 0 this
    // reduces to a plain lowest-index priority pick.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        best_age  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!sel_found || (age_val[i] > best_age))) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(i);
                best_age  = age_val[i];
            end
        end
    end

    assign issue_fire  = sel_found && issue_ready;
    assign issue_valid = sel_found;
    assign issue_id    = sel_id;
    assign issue_entry = sel_found ? rs_q[sel_id] : '0;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rs_full_reg      <= 1'b0;
            dispatch_err_reg <= 1'b0;
        end else begin
            rs_full_reg      <= &busy_next;
            dispatch_err_reg <= |err_slot;
        end
    end

    assign rs_full      = rs_full_reg;
    assign dispatch_err = dispatch_err_reg;

endmodule

// File: tb/tb_reservation_stations.sv
// Randomized + directed bench for reservation_stations against a behavioural station model.
// Follows the DUT build: RS_OLDEST_FIRST_EN switches the model's selection policy too.
module tb_reservation_stations;

    localparam int RS_SIZE = 8;
    localparam int ID_W    = 3;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 32;
    localparam int CTRL_W  = 8;
    localparam int LSQ_W   = 4;
    localparam int AGE_MAX = 15;

    typedef struct packed {
        logic              busy;
        logic [TAG_W-1:0]  tag;
        logic [TAG_W-1:0]  tag_1;
        logic [TAG_W-1:0]  tag_2;
        logic [DATA_W-1:0] value_1;
        logic [DATA_W-1:0] value_2;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl_bits;
        logic [LSQ_W-1:0]  lsq_id;
    } entry_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       flush;
    logic                       dispatch_valid;
    logic [ID_W-1:0]            dispatch_id;
    entry_t                     dispatch_entry;
    cdb_t                       cdb1;
    cdb_t                       cdb2;
    logic                       issue_ready;
    logic [RS_SIZE*ENTRY_W-1:0] res_stations;
    logic                       issue_valid;
    entry_t                     issue_entry;
    logic [ID_W-1:0]            issue_id;
    logic                       rs_full;
    logic                       dispatch_err;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;

    // Model state: what each station holds, how long it has waited, and the registered flags.
    entry_t m_rs  [RS_SIZE];
    int     m_age [RS_SIZE];
    bit     m_full;
    bit     m_err;

    reservation_stations #(.RS_SIZE(RS_SIZE), .AGE_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_id(dispatch_id), .dispatch_entry(dispatch_entry),
        .cdb1(cdb1), .cdb2(cdb2), .issue_ready(issue_ready),
        .res_stations(res_stations), .issue_valid(issue_valid), .issue_entry(issue_entry),
        .issue_id(issue_id), .rs_full(rs_full), .dispatch_err(dispatch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cycle_no, got, exp);
        end
    endtask

    function automatic entry_t dut_slot(input int s);
        return res_stations[s*ENTRY_W +: ENTRY_W];
    endfunction

    function automatic entry_t mk(input int tag, input int t1, input int t2, input int v1, input int v2);
        entry_t e;
        e         = '0;
        e.tag     = TAG_W'(tag);
        e.tag_1   = TAG_W'(t1);
        e.tag_2   = TAG_W'(t2);
        e.value_1 = DATA_W'(v1);
        e.value_2 = DATA_W'(v2);
        return e;
    endfunction

    function automatic bit m_ready(input int s);
        return m_rs[s].busy && m_rs[s].tag_1 == 0 && m_rs[s].tag_2 == 0;
    endfunction

    // Selection policy written as "find the winning age, then its first holder".
    function automatic int m_select();
        int best;
        best = -1;
`ifdef RS_OLDEST_FIRST_EN
        begin
            int max_age;
            max_age = -1;
            for (int s = 0; s < RS_SIZE; s++)
                if (m_ready(s) && m_age[s] > max_age) max_age = m_age[s];
            for (int s = 0; s < RS_SIZE; s++)
                if (best < 0 && m_ready(s) && m_age[s] == max_age) best = s;
        end
`else
        for (int s = 0; s < RS_SIZE; s++)
            if (best < 0 && m_ready(s)) best = s;
`endif
        return best;
    endfunction

    function automatic entry_t m_wake(input entry_t e);
        entry_t w;
        w = e;
        if (w.tag_1 != 0 && cdb1.tag == w.tag_1)      begin w.value_1 = cdb1.value; w.tag_1 = 0; end
        else if (w.tag_1 != 0 && cdb2.tag == w.tag_1) begin w.value_1 = cdb2.value; w.tag_1 = 0; end
        if (w.tag_2 != 0 && cdb1.tag == w.tag_2)      begin w.value_2 = cdb1.value; w.tag_2 = 0; end
        else if (w.tag_2 != 0 && cdb2.tag == w.tag_2) begin w.value_2 = cdb2.value; w.tag_2 = 0; end
        return w;
    endfunction

    task automatic model_step();
        entry_t nx [RS_SIZE];
        int     na [RS_SIZE];
        int     sel;
        bit     fire;
        bit     err;
        sel  = m_select();
        fire = (sel >= 0) && issue_ready;
        err  = 0;
        for (int s = 0; s < RS_SIZE; s++) begin
            nx[s] = m_rs[s];
            na[s] = m_age[s];
            if (fire && s == sel) begin
                nx[s] = '0;
                na[s] = 0;
            end else if (m_rs[s].busy) begin
                nx[s] = m_wake(m_rs[s]);
                na[s] = (m_age[s] < AGE_MAX) ? m_age[s] + 1 : AGE_MAX;
            end
        end
        if (dispatch_valid) begin
            if (m_rs[dispatch_id].busy) begin
                err = !(fire && sel == int'(dispatch_id));
            end else begin
                nx[dispatch_id]      = m_wake(dispatch_entry);
                nx[dispatch_id].busy = 1'b1;
                na[dispatch_id]      = 0;
            end
        end
        if (reset || flush) begin
            for (int s = 0; s < RS_SIZE; s++) begin
                nx[s] = '0;
                na[s] = 0;
            end
            err = 0;
        end
        m_full = 1;
        for (int s = 0; s < RS_SIZE; s++) begin
            m_rs[s]  = nx[s];
            m_age[s] = na[s];
            if (!nx[s].busy) m_full = 0;
        end
        m_err = err;
    endtask

    task automatic check_all();
        int sel;
        sel = m_select();
        for (int s = 0; s < RS_SIZE; s++)
            check($sformatf("slot%0d", s), dut_slot(s), m_rs[s]);
        check("issue_valid", issue_valid, sel >= 0);
        if (sel >= 0) begin
            check("issue_id", issue_id, sel);
            check("issue_entry", issue_entry, m_rs[sel]);
        end else begin
            check("issue_id", issue_id, 0);
            check("issue_entry", issue_entry, 0);
        end
        check("rs_full", rs_full, m_full);
        check("dispatch_err", dispatch_err, m_err);
    endtask

    // One clock: model consumes the driven inputs, DUT takes the edge, both compared mid-cycle.
    task automatic step();
        int sel;
        sel = m_select();
        if (dispatch_valid || (sel >= 0 && issue_ready) || flush || reset)
            $display("cycle %0d: rst=%0b flush=%0b disp=%0b@%0d issue=%0b@%0d", cycle_no, reset, flush,
                     dispatch_valid, dispatch_id, (sel >= 0) && issue_ready, sel);
        model_step();
        @(negedge clk);
        cycle_no++;
        check_all();
    endtask

    task automatic idle(input bit rdy);
        reset          = 0;
        flush          = 0;
        dispatch_valid = 0;
        dispatch_id    = '0;
        dispatch_entry = '0;
        cdb1           = '0;
        cdb2           = '0;
        issue_ready    = rdy;
    endtask

    task automatic disp(input int id, input entry_t e);
        dispatch_valid = 1;
        dispatch_id    = ID_W'(id);
        dispatch_entry = e;
    endtask

    function automatic int rnd_tag();
        return ($urandom_range(1) == 0) ? 0 : int'($urandom_range(7, 1));
    endfunction

    initial begin
        entry_t e;
        int first_id;
        for (int s = 0; s < RS_SIZE; s++) begin
            m_rs[s]  = '0;
            m_age[s] = 0;
        end
        idle(0);
        reset = 1;
        step();
        step();

        // Ready entry dispatched to slot 2 issues the following cycle.
        idle(1);
        disp(2, mk(5, 0, 0, 7, 3));
        step();
        idle(1);
        check("t1_valid", issue_valid, 1);
        check("t1_id", issue_id, 2);
        check("t1_value_1", issue_entry.value_1, 7);
        step();
        check("t1_cleared", dut_slot(2).busy, 0);

        // Operand wakeup from cdb2.
        disp(0, mk(6, 4, 0, 0, 2));
        step();
        idle(1);
        step();
        step();
        cdb2 = '{tag: 4, value: 32'h55};
        step();
        idle(1);
        check("t2_value_1", dut_slot(0).value_1, 32'h55);
        check("t2_tag_1", dut_slot(0).tag_1, 0);
        check("t2_valid", issue_valid, 1);
        step();

        // Wakeup in the dispatch cycle itself.
        idle(0);
        disp(1, mk(7, 9, 0, 0, 1));
        cdb1 = '{tag: 9, value: 32'h11};
        step();
        idle(1);
        check("t3_tag_1", dut_slot(1).tag_1, 0);
        check("t3_value_1", dut_slot(1).value_1, 32'h11);
        check("t3_id", issue_id, 1);
        step();

        // Fill every slot waiting on tag 3, poke a busy slot, then drain in order.
        for (int s = 0; s < RS_SIZE; s++) begin
            idle(1);
            disp(s, mk(8 + s, 3, 0, s, 0));
            step();
        end
        idle(1);
        check("t4_full", rs_full, 1);
        disp(4, mk(1, 0, 0, 99, 0));
        step();
        idle(1);
        check("t4_err", dispatch_err, 1);
        check("t4_unchanged", dut_slot(4).value_1, 4);
        cdb1 = '{tag: 3, value: 32'hAB};
        step();
        idle(1);
        for (int k = 0; k < RS_SIZE; k++) begin
            check("t4_order", issue_id, k);
            step();
        end
        check("t4_empty", issue_valid, 0);

        // Selection policy: slot 5 is older, slot 1 has the lower index.
        idle(0);
        disp(5, mk(2, 0, 0, 5, 0));
        step();
        idle(0);
        step();
        disp(1, mk(3, 0, 0, 1, 0));
        step();
        idle(0);
        step();
`ifdef RS_OLDEST_FIRST_EN
        first_id = 5;
`else
        first_id = 1;
`endif
        check("t5_first", issue_id, first_id);
        issue_ready = 1;
        step();
        check("t5_second", issue_id, 6 - first_id);
        step();

        // Flush wins over a simultaneous dispatch.
        idle(0);
        disp(2, mk(4, 0, 0, 1, 1));
        step();
        disp(3, mk(5, 2, 0, 1, 1));
        step();
        disp(6, mk(6, 0, 0, 1, 1));
        step();
        idle(0);
        flush = 1;
        disp(0, mk(7, 0, 0, 9, 9));
        step();
        idle(0);
        check("t6_valid", issue_valid, 0);
        check("t6_slot0", dut_slot(0).busy, 0);

        // Random traffic with occasional flush and one mid-run reset.
        for (int n = 0; n < 500; n++) begin
            idle($urandom_range(9) < 7);
            if ($urandom_range(9) < 6) begin
                e           = mk($urandom_range(63), rnd_tag(), rnd_tag(), $urandom, $urandom);
                e.busy      = 1'($urandom_range(1));
                e.imm       = $urandom;
                e.ctrl_bits = CTRL_W'($urandom);
                e.lsq_id    = LSQ_W'($urandom);
                disp($urandom_range(RS_SIZE - 1), e);
            end
            cdb1  = '{tag: TAG_W'($urandom_range(7)), value: $urandom};
            cdb2  = '{tag: TAG_W'($urandom_range(7)), value: $urandom};
            flush = ($urandom_range(49) == 0);
            reset = (n == 250);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
